airlock_sequencer: RTL and testbench
====================================

// Module: airlock_sequencer
// PURPOSE
//  Upstream controller for the airlock pressurizer. Turns level requests into a sequenced transit:
//  open door 1, close it, drive a pressure change, wait for it, open door 2, close it.
//  Drives the pressurizer's active-low pressurizeSignal/depressurizeSignal and both door states.
//  Consumes its pressurized flag. Pressurized chamber = inner (habitat) side; depressurized = outer side.
// PARAMETERS
//  DOOR_TICKS     4    cycles a door stays open per transit leg (>=1)
//  TIMEOUT_TICKS  32   max cycles to wait for pressurized to change (used only with AIRLOCK_TIMEOUT_EN)
//  CNT_W          6    counter width; must hold max(DOOR_TICKS, TIMEOUT_TICKS)
// PORTS
//  clk                 in   1  system clock, all logic on posedge
//  reset               in   1  synchronous, active-high
//  arriveReq           in   1  level; craft at outer door requests entry (outer -> inner)
//  departReq           in   1  level; occupant at inner door requests exit (inner -> outer)
//  pressurized         in   1  chamber pressure status from pressurizer
//  outerDoorState      out  1  1 = outer door open
//  innerDoorState      out  1  1 = inner door open
//  pressurizeSignal    out  1  active-low command to pressurizer
//  depressurizeSignal  out  1  active-low command to pressurizer
//  busy                out  1  1 whenever state != IDLE
//  fault               out  1  1 in FAULT state
// BEHAVIOUR
//  Reset: state=IDLE, both doors 0, pressurizeSignal=1, depressurizeSignal=1, busy=0, fault=0, counter=0.
//  Reset mid-transit: same values on the next edge. Open doors close immediately. Commands release. No resume.
//  Registered FSM. All outputs are registered or decoded from state only, with no input-to-output path.
//  States:
//   IDLE  : sample requests. Target dir: ARR if arriveReq only, DEP if departReq only.
//           If both are asserted, pick the one needing no pre-change: ARR if !pressurized, DEP if pressurized.
//           Chamber already matches door 1 (ARR & !pressurized, or DEP & pressurized) -> OPEN1, else -> PREP.
//   PREP  : drive command toward door-1 side (ARR: depressurizeSignal=0; DEP: pressurizeSignal=0).
//           Move to OPEN1 on the first cycle pressurized matches.
//   OPEN1 : door 1 open (ARR outer, DEP inner) for exactly DOOR_TICKS cycles, then -> CHG.
//           The door closes on the same edge as the state change.
//   CHG   : both doors 0. Drive command toward door-2 side (ARR: pressurizeSignal=0; DEP: depressurizeSignal=0).
//           -> OPEN2 when pressurized reaches the target.
//   OPEN2 : door 2 open for DOOR_TICKS cycles, then -> IDLE.
//   FAULT : doors 0, both commands 1, fault=1. Exit only via reset.
//  Invariants, checked by assertion:
//   - never both doors 1
//   - never a command low while any door is 1
//   - never both commands low
//  Requests are sampled only in IDLE. Requests while busy are ignored, not queued.
//  A request held after a transit completes starts a new transit from IDLE on the next cycle.
//  Command stays low for the whole PREP/CHG wait, then returns to 1 on the same edge the state leaves.
//  Counter resets to 0 on every state entry.
//  Door count runs 0..DOOR_TICKS-1. Leave the state when the count is DOOR_TICKS-1.
//  The counter saturates and never wraps.
//  Unused state encodings -> FAULT.
// CONFIGURATION
//  AIRLOCK_TIMEOUT_EN defined:
//   - PREP and CHG count cycles.
//   - If pressurized has not reached the target after TIMEOUT_TICKS cycles in the state -> FAULT.
//   - Reaching the target on the same cycle the count expires counts as success, not FAULT.
//  AIRLOCK_TIMEOUT_EN undefined:
//   - PREP and CHG wait indefinitely. FAULT is reachable only from illegal encodings.
//   - The fault output still exists.
// TESTING  (DOOR_TICKS=4, TIMEOUT_TICKS=32; bench models pressurizer flipping pressurized 8 cycles after command low)
//  1 reset=1 for 2 cycles -> doors 0, both commands 1, busy 0, fault 0
//  2 pressurized=0, arriveReq 1 cycle
//    -> busy next edge; outer door open 4 cycles; pressurizeSignal=0 until pressurized=1
//    -> inner door open 4 cycles -> IDLE
//  3 pressurized=0, departReq held
//    -> PREP with depressurizeSignal stays 1 and pressurizeSignal=0 until pressurized=1
//    -> inner open 4, depressurize, outer open 4 -> IDLE
//  4 both requests asserted, pressurized=1 -> DEP chosen; inner door opens first with no PREP
//  5 assert reset during CHG with pressurizeSignal=0 -> next edge: doors 0, commands 1, state IDLE
//  6 with AIRLOCK_TIMEOUT_EN, model never sets pressurized -> fault=1 after 32 cycles in CHG
//    -> stays in FAULT until reset; without the macro, still in CHG at cycle 100

Source files
------------

// File: rtl/airlock_sequencer.sv
// Airlock transit sequencer: door 1 open, pressure change, door 2 open, with registered FSM.
// Define AIRLOCK_TIMEOUT_EN to fault when a PREP/CHG pressure wait exceeds TIMEOUT_TICKS cycles.
module airlock_sequencer #(
  parameter int unsigned DOOR_TICKS    = 4,
  parameter int unsigned TIMEOUT_TICKS = 32,
  parameter int unsigned CNT_W         = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic arriveReq,
  input  logic departReq,
  input  logic pressurized,
  output logic outerDoorState,
  output logic innerDoorState,
  output logic pressurizeSignal,
  output logic depressurizeSignal,
  output logic busy,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    OPEN1 = 3'd2,
    CHG   = 3'd3,
    OPEN2 = 3'd4,
    FAULT = 3'd5
  } state_t;

  typedef enum logic {
    DIR_ARR = 1'b0,
    DIR_DEP = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] DOOR_LAST    = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

`ifdef AIRLOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state, state_next;
  dir_t             dir, dir_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pick_dep;
  logic             door1_ready;
  logic             door2_ready;
  logic             timed_out;

  // Door 1 side is depressurized for arrivals and pressurized for departures.
  assign door1_ready = (dir == DIR_DEP) ? pressurized : !pressurized;
  assign door2_ready = (dir == DIR_DEP) ? !pressurized : pressurized;
  assign timed_out   = TIMEOUT_EN && (cnt == TIMEOUT_LAST);

  always_comb begin
    state_next = state;
    dir_next   = dir;
    // With both requests up, the pressure state decides which transit needs no pre-change.
    pick_dep   = (arriveReq && departReq) ? pressurized : departReq;
    case (state)
      IDLE: begin
        if (arriveReq || departReq) begin
          dir_next   = pick_dep ? DIR_DEP : DIR_ARR;
          state_next = (pick_dep == pressurized) ? OPEN1 : PREP;
        end
      end
      PREP: begin
        if (door1_ready)    state_next = OPEN1;
        else if (timed_out) state_next = FAULT;
      end
      OPEN1: begin
        if (cnt == DOOR_LAST) state_next = CHG;
      end
      CHG: begin
        if (door2_ready)    state_next = OPEN2;
        else if (timed_out) state_next = FAULT;
      end
      OPEN2: begin
        if (cnt == DOOR_LAST) state_next = IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = FAULT;
    endcase

    if (state_next != state) cnt_next = '0;
    else if (cnt == '1)      cnt_next = cnt;
    else                     cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir   <= DIR_ARR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs decode only the registered state and direction.
  always_comb begin
    outerDoorState     = 1'b0;
    innerDoorState     = 1'b0;
    pressurizeSignal   = 1'b1;
    depressurizeSignal = 1'b1;
    case (state)
      PREP: begin
        if (dir == DIR_ARR) depressurizeSignal = 1'b0;
        else                pressurizeSignal   = 1'b0;
      end
      OPEN1: begin
        if (dir == DIR_ARR) outerDoorState = 1'b1;
        else                innerDoorState = 1'b1;
      end
      CHG: begin
        if (dir == DIR_ARR) pressurizeSignal   = 1'b0;
        else                depressurizeSignal = 1'b0;
      end
      OPEN2: begin
        if (dir == DIR_ARR) innerDoorState = 1'b1;
        else                outerDoorState = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign fault = (state == FAULT);

  a_one_door_max: assert property (@(posedge clk) !(outerDoorState && innerDoorState));
  a_no_cmd_door_open: assert property (@(posedge clk)
    !((outerDoorState || innerDoorState) && !(pressurizeSignal && depressurizeSignal)));
  a_one_cmd_max: assert property (@(posedge clk) pressurizeSignal || depressurizeSignal);

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: a pressurizer plant plus a transit-level model of expected output frames.
// Honours AIRLOCK_TIMEOUT_EN the same way as the design.
module tb_airlock_sequencer;

  localparam int unsigned DOOR_TICKS    = 4;
  localparam int unsigned TIMEOUT_TICKS = 32;

  // Frame layout: {outer, inner, pressurizeSignal, depressurizeSignal, busy, fault}
  typedef logic [5:0] frame_t;
  localparam frame_t F_IDLE  = 6'b00_11_00;
  localparam frame_t F_FAULT = 6'b00_11_11;

  logic clk = 1'b0;
  logic reset;
  logic arriveReq;
  logic departReq;
  logic pressurized;
  logic outerDoorState;
  logic innerDoorState;
  logic pressurizeSignal;
  logic depressurizeSignal;
  logic busy;
  logic fault;

  int tests_run    = 0;
  int tests_failed = 0;

  bit          plant_en    = 1'b1;
  int unsigned plant_delay = 8;
  int unsigned plant_cnt   = 0;
  frame_t      exp_q[$];

  airlock_sequencer #(
    .DOOR_TICKS(DOOR_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arriveReq(arriveReq),
    .departReq(departReq),
    .pressurized(pressurized),
    .outerDoorState(outerDoorState),
    .innerDoorState(innerDoorState),
    .pressurizeSignal(pressurizeSignal),
    .depressurizeSignal(depressurizeSignal),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic frame_t observed();
    return {outerDoorState, innerDoorState, pressurizeSignal, depressurizeSignal, busy, fault};
  endfunction

  function automatic frame_t door_frame(input bit outer);
    return outer ? 6'b10_11_10 : 6'b01_11_10;
  endfunction

  // Command frame driving the chamber toward the pressurized (inner) or vacuum (outer) side.
  function automatic frame_t cmd_frame(input bit toward_pressurized);
    return toward_pressurized ? 6'b00_01_10 : 6'b00_10_10;
  endfunction

  // A transit as legs: optional pre-change, door 1, pressure change, door 2.
  function automatic void plan_transit(input bit dep_dir, input bit need_prep, input int unsigned d);
    exp_q.delete();
    if (need_prep) repeat (d) exp_q.push_back(cmd_frame(dep_dir));
    repeat (DOOR_TICKS) exp_q.push_back(door_frame(!dep_dir));
    repeat (d) exp_q.push_back(cmd_frame(!dep_dir));
    repeat (DOOR_TICKS) exp_q.push_back(door_frame(dep_dir));
  endfunction

  // Pressurizer: flips its flag after plant_delay consecutive cycles of a relevant command.
  task automatic plant_step();
    if (!plant_en) begin
      plant_cnt = 0;
    end else if (!pressurizeSignal && !pressurized) begin
      plant_cnt++;
      if (plant_cnt >= plant_delay) begin
        pressurized = 1'b1;
        plant_cnt   = 0;
      end
    end else if (!depressurizeSignal && pressurized) begin
      plant_cnt++;
      if (plant_cnt >= plant_delay) begin
        pressurized = 1'b0;
        plant_cnt   = 0;
      end
    end else begin
      plant_cnt = 0;
    end
  endtask

  // Starts from IDLE; checks every transit frame plus the IDLE frame that follows.
  task automatic run_transit(input string name, input bit arr, input bit dep,
                             input int unsigned d, input bit hold, input bit noise);
    bit          dep_dir;
    bit          need_prep;
    int unsigned n;
    frame_t      got;
    if (arr && !dep)      dep_dir = 1'b0;
    else if (dep && !arr) dep_dir = 1'b1;
    else                  dep_dir = pressurized;
    need_prep   = dep_dir ? !pressurized : pressurized;
    plant_delay = d;
    plan_transit(dep_dir, need_prep, d);
    exp_q.push_back(F_IDLE);
    arriveReq = arr;
    departReq = dep;
    n = exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      got = observed();
      tests_run++;
      if (got !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i, got, exp_q[i]);
      end
      plant_step();
      if (!hold) begin
        if (noise && i + 1 < n) begin
          arriveReq = 1'($urandom);
          departReq = 1'($urandom);
        end else begin
          arriveReq = 1'b0;
          departReq = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    frame_t got;
    reset = 1'b1; arriveReq = 1'b0; departReq = 1'b0; pressurized = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      got = observed();
      tests_run++;
      if (got !== F_IDLE) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, got, F_IDLE);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    got = observed();
    tests_run++;
    if (got !== F_IDLE) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected %b", got, F_IDLE);
    end
  endtask

  task automatic test_arrive();
    pressurized = 1'b0;
    run_transit("arrive", 1'b1, 1'b0, 8, 1'b0, 1'b0);
  endtask

  task automatic test_depart_held();
    frame_t got;
    pressurized = 1'b0;
    run_transit("depart_held", 1'b0, 1'b1, 8, 1'b1, 1'b0);
    // Still held: a fresh departure with the chamber at vacuum must start with a pre-change.
    @(negedge clk);
    got = observed();
    tests_run++;
    if (got !== cmd_frame(1'b1)) begin
      tests_failed++;
      $display("FAIL depart_restart: got %b expected %b", got, cmd_frame(1'b1));
    end
    plant_step();
    departReq = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    got = observed();
    tests_run++;
    if (got !== F_IDLE) begin
      tests_failed++;
      $display("FAIL depart_cleanup: got %b expected %b", got, F_IDLE);
    end
    plant_step();
    reset = 1'b0;
  endtask

  task automatic test_both_requests();
    pressurized = 1'b1;
    run_transit("both_dep", 1'b1, 1'b1, 8, 1'b0, 1'b0);
    pressurized = 1'b0;
    run_transit("both_arr", 1'b1, 1'b1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midtransit();
    int unsigned stop;
    frame_t      got;
    for (int unsigned s = 0; s < 2; s++) begin
      stop = (s == 0) ? DOOR_TICKS + 3 : 2;
      pressurized = 1'b0;
      plant_delay = 8;
      plan_transit(1'b0, 1'b0, 8);
      arriveReq = 1'b1;
      for (int unsigned i = 0; i < stop; i++) begin
        @(negedge clk);
        got = observed();
        tests_run++;
        if (got !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL midreset_run%0d cycle %0d: got %b expected %b", s, i, got, exp_q[i]);
        end
        plant_step();
        arriveReq = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      got = observed();
      tests_run++;
      if (got !== F_IDLE) begin
        tests_failed++;
        $display("FAIL midreset_abort%0d: got %b expected %b", s, got, F_IDLE);
      end
      plant_step();
      reset = 1'b0;
      @(negedge clk);
      got = observed();
      tests_run++;
      if (got !== F_IDLE) begin
        tests_failed++;
        $display("FAIL midreset_noresume%0d: got %b expected %b", s, got, F_IDLE);
      end
      plant_step();
    end
  endtask

  task automatic test_slow_plant();
    pressurized = 1'b0;
    run_transit("slow_arrive", 1'b1, 1'b0, TIMEOUT_TICKS, 1'b0, 1'b0);
    pressurized = 1'b0;
    run_transit("slow_depart", 1'b0, 1'b1, TIMEOUT_TICKS, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_plant();
    frame_t got;
    frame_t exp;
    int unsigned wait_cycles;
    plant_en = 1'b0;
    pressurized = 1'b0;
    arriveReq = 1'b1;
`ifdef AIRLOCK_TIMEOUT_EN
    wait_cycles = TIMEOUT_TICKS;
`else
    wait_cycles = 100;
`endif
    for (int unsigned i = 0; i < DOOR_TICKS + wait_cycles + 10; i++) begin
      @(negedge clk);
      if (i < DOOR_TICKS)                    exp = door_frame(1'b1);
      else if (i < DOOR_TICKS + wait_cycles) exp = cmd_frame(1'b1);
`ifdef AIRLOCK_TIMEOUT_EN
      else                                   exp = F_FAULT;
`else
      else                                   exp = cmd_frame(1'b1);
`endif
      got = observed();
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL stuck cycle %0d: got %b expected %b", i, got, exp);
      end
      arriveReq = 1'($urandom);
      departReq = 1'($urandom);
    end
    arriveReq = 1'b0;
    departReq = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    got = observed();
    tests_run++;
    if (got !== F_IDLE) begin
      tests_failed++;
      $display("FAIL stuck_reset: got %b expected %b", got, F_IDLE);
    end
    reset = 1'b0;
    plant_en = 1'b1;
  endtask

  task automatic test_random();
    bit          arr;
    bit          dep;
    int unsigned gap;
    frame_t      got;
    for (int unsigned t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 3);
      for (int unsigned g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) pressurized = 1'($urandom);
        @(negedge clk);
        got = observed();
        tests_run++;
        if (got !== F_IDLE) begin
          tests_failed++;
          $display("FAIL random_gap t%0d: got %b expected %b", t, got, F_IDLE);
        end
      end
      if ($urandom_range(0, 3) == 0) pressurized = 1'($urandom);
      arr = 1'($urandom);
      dep = 1'($urandom);
      if (!arr && !dep) arr = 1'b1;
      run_transit($sformatf("random_t%0d", t), arr, dep, $urandom_range(1, 12), 1'b0, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arrive();
    test_depart_held();
    test_both_requests();
    test_reset_midtransit();
    test_slow_plant();
    test_stuck_plant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
